// File: rtl/uart_rx_buffer.sv
// Receive-side FIFO behind the UART receiver, exposed to the MIPS bus as an
// RX data register and a control/status register, with a level interrupt.
module uart_rx_buffer #(
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [31:0] ADDR_RXD   = 32'h4000_001C,
    parameter logic [31:0] ADDR_CON   = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_STATUS,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int                DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            fifo [DEPTH];
    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  overflow;
    logic                  ien;
    logic                  ien_next;
    logic                  rx_status_d;

    logic push;
    logic pop;
    logic push_ok;
    logic drop;
    logic full;
    logic not_empty;
    logic con_wr;

    assign not_empty = (count != '0);
    assign full      = (count == FULL_COUNT);
    assign push      = RX_STATUS & ~rx_status_d;
    assign pop       = rd & (addr == ADDR_RXD) & not_empty;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign push_ok   = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign con_wr    = wr & (addr == ADDR_CON);
    assign ien_next  = con_wr ? wdata[3] : ien;

    logic unused_wdata_bits;
    assign unused_wdata_bits = ^{wdata[31:4], wdata[1:0]};

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_next = count - (DEPTH_LOG2 + 1)'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (addr == ADDR_RXD) begin
            if (not_empty) begin
                rdata = {24'b0, fifo[head]};
            end
        end else if (addr == ADDR_CON) begin
            rdata[0]                = not_empty;
            rdata[1]                = full;
            rdata[2]                = overflow;
            rdata[3]                = ien;
            rdata[8 +: DEPTH_LOG2+1] = count;
        end
    end

    // rx_status_d resets high so a level already asserted at reset release is not pushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            ien         <= 1'b0;
            irq         <= 1'b0;
            rx_status_d <= 1'b1;
        end else begin
            rx_status_d <= RX_STATUS;
            if (push_ok) begin
                fifo[tail] <= RX_DATA;
                tail       <= tail + (DEPTH_LOG2)'(1);
            end
            if (pop) begin
                head <= head + (DEPTH_LOG2)'(1);
            end
            count <= count_next;
            ien   <= ien_next;
            if (drop) begin
                overflow <= 1'b1;
            end else if (con_wr && wdata[2]) begin
                overflow <= 1'b0;
            end
            irq <= ien_next & (count_next != '0);
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed scenarios plus a random
// phase, all checked against a queue-based model of the receive FIFO.
module tb_uart_rx_buffer;

    localparam int          DEPTH_LOG2 = 3;
    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [31:0] ADDR_RXD   = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON   = 32'h4000_0020;
    localparam logic [31:0] ADDR_OTHER = 32'h4000_0024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_STATUS = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;

    int testCount = 0;
    int failCount = 0;

    logic [7:0] mQueue[$];
    logic       mOverflow = 1'b0;
    logic       mIen = 1'b0;
    logic       mPrevStatus = 1'b1;

    uart_rx_buffer #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .ADDR_RXD  (ADDR_RXD),
        .ADDR_CON  (ADDR_CON)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .RX_DATA  (RX_DATA),
        .RX_STATUS(RX_STATUS),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelRdata(input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = mQueue.size();
        if (a == ADDR_RXD) begin
            if (n != 0) v = {24'h0, mQueue[0]};
        end else if (a == ADDR_CON) begin
            v = (n << 8) | (32'(mIen) << 3) | (32'(mOverflow) << 2)
              | ((n == DEPTH) ? 32'h2 : 32'h0) | ((n != 0) ? 32'h1 : 32'h0);
        end
        return v;
    endfunction

    // One bus/receiver cycle: rdata checked before the edge, irq after it.
    task automatic applyStimulus(input string tag, input logic st, input logic [7:0] d,
                                 input logic r, input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input bit useExp, input logic [31:0] expRdata);
        logic doPush;
        logic doPop;
        logic dropEvt;
        @(negedge clk);
        RX_STATUS = st;
        RX_DATA   = d;
        rd        = r;
        wr        = w;
        addr      = a;
        wdata     = wd;
        #1;
        checkOutput({tag, "_rdata"}, rdata, modelRdata(a));
        if (useExp) checkOutput({tag, "_const"}, rdata, expRdata);
        doPush      = st & ~mPrevStatus;
        mPrevStatus = st;
        doPop       = r && (a == ADDR_RXD) && (mQueue.size() != 0);
        dropEvt     = doPush && (mQueue.size() == DEPTH) && !doPop;
        if (doPop) void'(mQueue.pop_front());
        if (doPush && !dropEvt) mQueue.push_back(d);
        if (w && a == ADDR_CON) begin
            mIen = wd[3];
            if (wd[2]) mOverflow = 1'b0;
        end
        if (dropEvt) mOverflow = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_irq"}, {31'h0, irq}, {31'h0, mIen && (mQueue.size() != 0)});
    endtask

    task automatic applyReset(input logic st, input int cycles);
        @(negedge clk);
        reset     = 1'b1;
        RX_STATUS = st;
        rd        = 1'b0;
        wr        = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        mQueue.delete();
        mOverflow   = 1'b0;
        mIen        = 1'b0;
        mPrevStatus = 1'b1;
        checkOutput("reset_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mPrevStatus = st;
    endtask

    task automatic pushByte(input string tag, input logic [7:0] d);
        applyStimulus(tag, 1'b1, d, 1'b0, 1'b0, ADDR_OTHER, 32'h0, 1'b0, 32'h0);
        applyStimulus(tag, 1'b0, d, 1'b0, 1'b0, ADDR_OTHER, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic readReg(input string tag, input logic [31:0] a, input logic doRd, input logic [31:0] expV);
        applyStimulus(tag, 1'b0, 8'h00, doRd, 1'b0, a, 32'h0, 1'b1, expV);
    endtask

    initial begin
        applyReset(1'b0, 2);
        readReg("reset_con", ADDR_CON, 1'b0, 32'h0);

        // Long RX_STATUS level produces exactly one push.
        repeat (5) applyStimulus("hold", 1'b1, 8'hA5, 1'b0, 1'b0, ADDR_OTHER, 32'h0, 1'b0, 32'h0);
        readReg("hold_con", ADDR_CON, 1'b0, 32'h0000_0101);
        readReg("hold_rxd", ADDR_RXD, 1'b1, 32'h0000_00A5);
        readReg("hold_empty", ADDR_CON, 1'b0, 32'h0);

        for (int i = 1; i <= 8; i++) pushByte("fill", 8'(i));
        readReg("full_con", ADDR_CON, 1'b0, 32'h0000_0803);
        pushByte("ovf", 8'h09);
        readReg("ovf_con", ADDR_CON, 1'b0, 32'h0000_0807);
        for (int i = 1; i <= 8; i++) readReg("drain", ADDR_RXD, 1'b1, 32'(i));
        readReg("drain_empty", ADDR_RXD, 1'b1, 32'h0);
        readReg("drain_con", ADDR_CON, 1'b0, 32'h0000_0004);

        applyStimulus("clr", 1'b0, 8'h00, 1'b0, 1'b1, ADDR_CON, 32'h4, 1'b0, 32'h0);
        readReg("clr_con", ADDR_CON, 1'b0, 32'h0);
        applyStimulus("ien", 1'b0, 8'h00, 1'b0, 1'b1, ADDR_CON, 32'h8, 1'b0, 32'h0);
        checkOutput("ien_empty_irq", {31'h0, irq}, 32'h0);
        applyStimulus("irq_push", 1'b1, 8'h3C, 1'b0, 1'b0, ADDR_OTHER, 32'h0, 1'b0, 32'h0);
        checkOutput("irq_set", {31'h0, irq}, 32'h1);
        readReg("irq_pop", ADDR_RXD, 1'b1, 32'h0000_003C);
        checkOutput("irq_clear", {31'h0, irq}, 32'h0);

        for (int i = 0; i < 8; i++) pushByte("fill2", 8'h10 + 8'(i));
        readReg("full2_con", ADDR_CON, 1'b0, 32'h0000_080B);
        applyStimulus("full_pp", 1'b1, 8'hE1, 1'b1, 1'b0, ADDR_RXD, 32'h0, 1'b1, 32'h0000_0010);
        readReg("full_pp_con", ADDR_CON, 1'b0, 32'h0000_080B);
        for (int i = 1; i < 8; i++) readReg("drain2", ADDR_RXD, 1'b1, 32'h10 + 32'(i));
        readReg("drain2_last", ADDR_RXD, 1'b1, 32'h0000_00E1);

        applyStimulus("empty_pp", 1'b1, 8'h77, 1'b1, 1'b0, ADDR_RXD, 32'h0, 1'b1, 32'h0);
        readReg("empty_pp_con", ADDR_CON, 1'b0, 32'h0000_0109);
        readReg("empty_pp_rxd", ADDR_RXD, 1'b1, 32'h0000_0077);

        for (int i = 0; i < 3; i++) pushByte("pre_rst", 8'hC0 + 8'(i));
        applyStimulus("pre_rst_hold", 1'b1, 8'hEE, 1'b0, 1'b0, ADDR_OTHER, 32'h0, 1'b0, 32'h0);
        applyReset(1'b1, 2);
        repeat (3) applyStimulus("post_rst", 1'b1, 8'h55, 1'b0, 1'b0, ADDR_OTHER, 32'h0, 1'b0, 32'h0);
        applyStimulus("post_rst_con", 1'b1, 8'h55, 1'b0, 1'b0, ADDR_CON, 32'h0, 1'b1, 32'h0);
        checkOutput("post_rst_irq", {31'h0, irq}, 32'h0);

        // Random traffic: a push-heavy phase first to reach overflow, then balanced.
        for (int i = 0; i < 800; i++) begin
            logic        st;
            logic        r;
            logic        w;
            logic [31:0] a;
            int          sel;
            st  = 1'($urandom_range(0, 1));
            r   = (i < 300) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
            w   = ($urandom_range(0, 15) == 0);
            sel = $urandom_range(0, 3);
            a   = (sel < 2) ? ADDR_RXD : ((sel == 2) ? ADDR_CON : ADDR_OTHER);
            if (w && $urandom_range(0, 1) == 1) a = ADDR_CON;
            applyStimulus("rand", st, 8'($urandom), r, w, a, $urandom, 1'b0, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
